// File: rtl/quadrilatero_sa_dispatcher.sv
// -----------------------------------------------------------------------------
// quadrilatero_sa_dispatcher
//
// Hazard-checking dispatch stage that sits in front of the systolic-array issue
// queue. Decoded matrix instructions arrive on a valid/ready handshake. The
// stage keeps a scoreboard for every matrix register:
//   - one pending-writer bit
//   - an outstanding-reader count
// It stalls on RAW/WAW/WAR hazards, on reader-count saturation, or when the
// issue queue is full. Hazard-free instructions are pushed to the queue one
// cycle after acceptance through a registered dispatch strobe.
//
// Ports
//   clk_i, rst_i                         clock, async active-high reset
//   instr_valid_i / instr_ready_o        instruction handshake
//   instr_i, rs1_i, rs2_i, rd_i          payload and register operands
//   queue_full_i                         issue queue cannot take another entry
//   dispatch_o, dispatched_instr_o       registered push into the issue queue
//   wr_release_i, wr_release_idx_i       writer of a register has committed
//   rd_release_i, rd_release_rs1_i/rs2_i an instruction finished reading sources
//   idle_o                               scoreboard empty, no dispatch in flight
//   sb_error_o                           sticky release-of-idle / underflow flag
// -----------------------------------------------------------------------------
module quadrilatero_sa_dispatcher #(
    parameter int N_REGS      = 8,
    parameter int REG_IDX_W   = 3,
    parameter int INSTR_W     = 64,
    parameter int MAX_READERS = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [INSTR_W-1:0]   instr_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    input  logic                 queue_full_i,
    output logic                 dispatch_o,
    output logic [INSTR_W-1:0]   dispatched_instr_o,
    input  logic                 wr_release_i,
    input  logic [REG_IDX_W-1:0] wr_release_idx_i,
    input  logic                 rd_release_i,
    input  logic [REG_IDX_W-1:0] rd_release_rs1_i,
    input  logic [REG_IDX_W-1:0] rd_release_rs2_i,
    output logic                 idle_o,
    output logic                 sb_error_o
);

    localparam int CNT_W = $clog2(MAX_READERS + 1);
    // Two extra bits so count + 2 (and the underflow test) never wraps.
    localparam int SUM_W = CNT_W + 2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [SUM_W-1:0] sum_t;

    logic [N_REGS-1:0] wr_busy_q;
    logic [N_REGS-1:0] wr_busy_d;
    cnt_t              rd_cnt_q [N_REGS];
    cnt_t              rd_cnt_d [N_REGS];

    logic hazard;
    logic accept;
    logic err_d;
    logic readers_idle;
    sum_t src_inc;
    sum_t inc_r;
    sum_t dec_r;
    sum_t total_r;

    // ------------------------------------------------------------------
    // Hazard detection: registered scoreboard only, no release bypass.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        hazard  = 1'b0;
        // rs1 == rs2 consumes two reader slots on the same register.
        src_inc = (rs1_i == rs2_i) ? sum_t'(2) : sum_t'(1);

        if (wr_busy_q[rs1_i] || wr_busy_q[rs2_i]) hazard = 1'b1;   // RAW
        if (wr_busy_q[rd_i])                      hazard = 1'b1;   // WAW
        if (rd_cnt_q[rd_i] != '0)                 hazard = 1'b1;   // WAR
        if ((sum_t'(rd_cnt_q[rs1_i]) + src_inc) > sum_t'(MAX_READERS) ||
            (sum_t'(rd_cnt_q[rs2_i]) + src_inc) > sum_t'(MAX_READERS))
            hazard = 1'b1;                                          // saturation
    end

    assign instr_ready_o = !rst_i && !queue_full_i && !hazard;
    assign accept        = instr_valid_i && instr_ready_o;

    // ------------------------------------------------------------------
    // Scoreboard next state.
    // ------------------------------------------------------------------
    always_comb begin
        wr_busy_d = wr_busy_q;
        err_d     = 1'b0;
        inc_r     = '0;
        dec_r     = '0;
        total_r   = '0;

        if (wr_release_i) begin
            if (wr_busy_q[wr_release_idx_i]) wr_busy_d[wr_release_idx_i] = 1'b0;
            else                             err_d = 1'b1;
        end
        // Applied after the release so an acquire of the same register wins.
        if (accept) wr_busy_d[rd_i] = 1'b1;

        // Reader counters take the net of this cycle's acquires and releases;
        // a net result below zero is flagged and only the acquire is kept.
        for (int r = 0; r < N_REGS; r++) begin
            inc_r   = sum_t'(accept && (rs1_i == REG_IDX_W'(r))) +
                      sum_t'(accept && (rs2_i == REG_IDX_W'(r)));
            dec_r   = sum_t'(rd_release_i && (rd_release_rs1_i == REG_IDX_W'(r))) +
                      sum_t'(rd_release_i && (rd_release_rs2_i == REG_IDX_W'(r)));
            total_r = sum_t'(rd_cnt_q[r]) + inc_r;
            if (total_r < dec_r) begin
                err_d       = 1'b1;
                rd_cnt_d[r] = cnt_t'(total_r);
            end else begin
                rd_cnt_d[r] = cnt_t'(total_r - dec_r);
            end
        end
    end

    always_comb begin
        readers_idle = 1'b1;
        for (int r = 0; r < N_REGS; r++) begin
            if (rd_cnt_q[r] != '0) readers_idle = 1'b0;
        end
    end

    assign idle_o = !(|wr_busy_q) && readers_idle && !dispatch_o;

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_busy_q          <= '0;
            // NOTE: the reader counters are control state, not a data store,
            // so every entry must be cleared by reset.
            for (int r = 0; r < N_REGS; r++) rd_cnt_q[r] <= '0;
            dispatch_o         <= 1'b0;
            dispatched_instr_o <= '0;
            sb_error_o         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values regardless of statement order.
            wr_busy_q  <= wr_busy_d;
            rd_cnt_q   <= rd_cnt_d;
            dispatch_o <= accept;
            if (accept) dispatched_instr_o <= instr_i;
            if (err_d)  sb_error_o <= 1'b1;
        end
    end

endmodule
